// File: rtl/unidad_datos_p_if.sv
// Data-RAM handshake bundle for the DAPA datapath.
// The master (datapath) presents address, write data, request and direction.
// The slave (RAM) returns read data and the completion acknowledge.
interface unidad_datos_p_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_req;
    logic          ram_we;
    logic          ram_ack;

    modport master (
        output ram_addr,
        output ram_wdata,
        output ram_req,
        output ram_we,
        input  ram_rdata,
        input  ram_ack
    );

    modport slave (
        input  ram_addr,
        input  ram_wdata,
        input  ram_req,
        input  ram_we,
        output ram_rdata,
        output ram_ack
    );
endinterface

// File: rtl/unidad_datos_p.sv
// DAPA datapath: PC, SP, AC, IR, SR, MAR, MDR, register file and ALU around a
// priority-muxed internal bus with multiple-driver detection. Data RAM is
// reached through a req/ack handshake run by a small transfer FSM that stalls
// the control unit through busy.
module unidad_datos_p #(
    parameter int            DW      = 8,
    parameter int            AW      = 8,
    parameter int            NREG    = 8,
    parameter logic [AW-1:0] SP_INIT = '1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wreg,
    input  logic            ws,
    input  logic            inm,
    input  logic            wac,
    input  logic            rac,
    input  logic            isp,
    input  logic            dsp,
    input  logic            csp,
    input  logic            rsp,
    input  logic            ipc,
    input  logic            wpc,
    input  logic            rpc,
    input  logic            wir,
    input  logic            cpc,
    input  logic            wmar,
    input  logic            wmdr,
    input  logic            rmdr,
    input  logic [3:0]      op,
    input  logic            rmem,
    input  logic            wmem,
    output logic [AW-1:0]   code_addr,
    input  logic [2*DW-1:0] code_data,
    unidad_datos_p_if.master ram,
    output logic            busy,
    output logic [DW-1:0]   ir_hi,
    output logic            v,
    output logic            n,
    output logic            z,
    output logic            c,
    output logic            stk_ovf,
    output logic            stk_unf,
    output logic            bus_err
);

    localparam int RSW = $clog2(NREG);
    localparam logic [DW-1:0] ONE = DW'(1);

    typedef enum logic [3:0] {
        OP_B, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC,
        OP_DEC, OP_SHL, OP_SHR, OP_ADC, OP_SBC, OP_CMP, OP_A, OP_ZERO
    } alu_op_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_RD,
        XF_WR
    } xfer_e;

    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   sp_q, sp_d;
    logic [AW-1:0]   mar_q;
    logic [DW-1:0]   ac_q;
    logic [DW-1:0]   mdr_q;
    logic [2*DW-1:0] ir_q;
    logic [DW-1:0]   regs_q [NREG];
    logic            v_q, n_q, z_q, c_q;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            berr_q;
    xfer_e           state_q, state_d;

    logic [DW-1:0]   bus;
    logic            bus_conflict;
    logic [RSW-1:0]  rd, ra;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   opa, opb;
    alu_op_e         alu_op;
    logic [DW-1:0]   alu_res;
    logic            alu_c, alu_v;
    logic            read_done;

    function automatic logic ovf_add(input logic [DW-1:0] x, y, r);
        return (x[DW-1] == y[DW-1]) && (r[DW-1] != x[DW-1]);
    endfunction

    function automatic logic ovf_sub(input logic [DW-1:0] x, y, r);
        return (x[DW-1] != y[DW-1]) && (r[DW-1] != x[DW-1]);
    endfunction

    assign rd     = ir_q[DW+RSW-1:DW];
    assign ra     = ir_q[RSW-1:0];
    assign imm    = ir_q[DW-1:0];
    assign opa    = regs_q[rd];
    assign opb    = inm ? imm : regs_q[ra];
    assign alu_op = alu_op_e'(op);

    // Internal bus source select, fixed priority rpc > rsp > rac > rmdr
    always_comb begin
        bus = '0;
        if (rpc)       bus = DW'(pc_q);
        else if (rsp)  bus = DW'(sp_q);
        else if (rac)  bus = ac_q;
        else if (rmdr) bus = mdr_q;
    end

    assign bus_conflict = (rpc & (rsp | rac | rmdr)) | (rsp & (rac | rmdr)) | (rac & rmdr);

    // ALU: result plus carry/borrow and signed-overflow for the add/sub family
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            OP_B:    alu_res = opb;
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
                alu_v = ovf_add(opa, opb, alu_res);
            end
            OP_SUB, OP_CMP: begin
                {alu_c, alu_res} = {1'b0, opa} - {1'b0, opb};
                alu_v = ovf_sub(opa, opb, alu_res);
            end
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_NOT:  alu_res = ~opa;
            OP_INC: begin
                {alu_c, alu_res} = {1'b0, opa} + {1'b0, ONE};
                alu_v = ovf_add(opa, ONE, alu_res);
            end
            OP_DEC: begin
                {alu_c, alu_res} = {1'b0, opa} - {1'b0, ONE};
                alu_v = ovf_sub(opa, ONE, alu_res);
            end
            OP_SHL: begin
                alu_res = {opa[DW-2:0], 1'b0};
                alu_c   = opa[DW-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa[DW-1:1]};
                alu_c   = opa[0];
            end
            OP_ADC: begin
                {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb} + {{DW{1'b0}}, c_q};
                alu_v = ovf_add(opa, opb, alu_res);
            end
            OP_SBC: begin
                {alu_c, alu_res} = {1'b0, opa} - {1'b0, opb} - {{DW{1'b0}}, ~c_q};
                alu_v = ovf_sub(opa, opb, alu_res);
            end
            OP_A:    alu_res = opa;
            OP_ZERO: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // PC next value: clear > load from bus > increment (wraps naturally)
    always_comb begin
        pc_d = pc_q;
        if (cpc)      pc_d = '0;
        else if (wpc) pc_d = AW'(bus);
        else if (ipc) pc_d = pc_q + AW'(1);
    end

    // SP next value with saturating limits and sticky over/underflow
    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (csp) begin
            sp_d  = SP_INIT;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (isp && !dsp) begin
            if (sp_q == '1) ovf_d = 1'b1;
            else            sp_d  = sp_q + AW'(1);
        end else if (dsp && !isp) begin
            if (sp_q == '0) unf_d = 1'b1;
            else            sp_d  = sp_q - AW'(1);
        end
    end

    // Program counter and stack pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            sp_q  <= SP_INIT;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Accumulator, status flags and instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac_q <= '0;
            ir_q <= '0;
            v_q  <= 1'b0;
            n_q  <= 1'b0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            if (wac && alu_op != OP_CMP) ac_q <= alu_res;
            if (ws) begin
                v_q <= alu_v;
                n_q <= alu_res[DW-1];
                z_q <= (alu_res == '0);
                c_q <= alu_c;
            end
            if (wir) ir_q <= code_data;
        end
    end

    // Register file written from the bus; reads see the pre-edge contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wreg) begin
            regs_q[rd] <= bus;
        end
    end

    assign read_done = (state_q == XF_RD) && ram.ram_ack;

    // MAR/MDR: a completing RAM read takes precedence over a bus load of MDR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            if (wmar) mar_q <= AW'(bus);
            if (read_done)  mdr_q <= ram.ram_rdata;
            else if (wmdr)  mdr_q <= bus;
        end
    end

    // Sticky multiple-driver detector on the internal bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            berr_q <= 1'b0;
        else if (bus_conflict) berr_q <= 1'b1;
    end

    // Transfer FSM state register; reset forces IDLE, dropping req at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= XF_IDLE;
        else        state_q <= state_d;
    end

    // Transfer FSM next state and handshake outputs
    always_comb begin
        state_d      = state_q;
        ram.ram_req  = 1'b0;
        ram.ram_we   = 1'b0;
        busy         = 1'b0;
        case (state_q)
            XF_IDLE: begin
                if (wmem)      state_d = XF_WR;
                else if (rmem) state_d = XF_RD;
            end
            XF_RD: begin
                ram.ram_req = 1'b1;
                busy        = 1'b1;
                if (ram.ram_ack) state_d = XF_IDLE;
            end
            XF_WR: begin
                ram.ram_req = 1'b1;
                ram.ram_we  = 1'b1;
                busy        = 1'b1;
                if (ram.ram_ack) state_d = XF_IDLE;
            end
            default: state_d = XF_IDLE;
        endcase
    end

    assign ram.ram_addr  = mar_q;
    assign ram.ram_wdata = mdr_q;
    assign code_addr     = pc_q;
    assign ir_hi         = ir_q[2*DW-1:DW];
    assign v             = v_q;
    assign n             = n_q;
    assign z             = z_q;
    assign c             = c_q;
    assign stk_ovf       = ovf_q;
    assign stk_unf       = unf_q;
    assign bus_err       = berr_q;

endmodule

// File: tb/tb_unidad_datos_p.sv
// Self-checking bench for unidad_datos_p: ALU vector table, hand-written
// multi-cycle sequences, then randomized cycles against a behavioural model.
module tb_unidad_datos_p;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int NREG = 8;

    logic            clk, reset;
    logic            wreg, ws, inm, wac, rac, isp, dsp, csp, rsp;
    logic            ipc, wpc, rpc, wir, cpc, wmar, wmdr, rmdr;
    logic [3:0]      op;
    logic            rmem, wmem;
    logic [AW-1:0]   code_addr;
    logic [2*DW-1:0] code_data;
    logic            busy;
    logic [DW-1:0]   ir_hi;
    logic            v, n, z, c, stk_ovf, stk_unf, bus_err;

    unidad_datos_p_if #(.DW(DW), .AW(AW)) ram_if ();

    unidad_datos_p #(.DW(DW), .AW(AW), .NREG(NREG), .SP_INIT(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .wreg(wreg), .ws(ws), .inm(inm), .wac(wac), .rac(rac), .isp(isp),
        .dsp(dsp), .csp(csp), .rsp(rsp), .ipc(ipc), .wpc(wpc), .rpc(rpc),
        .wir(wir), .cpc(cpc), .wmar(wmar), .wmdr(wmdr), .rmdr(rmdr),
        .op(op), .rmem(rmem), .wmem(wmem),
        .code_addr(code_addr), .code_data(code_data),
        .ram(ram_if),
        .busy(busy), .ir_hi(ir_hi),
        .v(v), .n(n), .z(z), .c(c),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        {wreg, ws, inm, wac, rac, isp, dsp, csp, rsp} = '0;
        {ipc, wpc, rpc, wir, cpc, wmar, wmdr, rmdr} = '0;
        {rmem, wmem} = '0;
        op = '0;
        ram_if.ram_ack = 1'b0;
    endtask

    // apply the currently driven strobes for one edge, return at the next negedge
    task automatic pulse();
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic load_ir(input logic [15:0] val);
        code_data = val; wir = 1'b1; pulse();
    endtask

    // reg[rd] <= imm via AC, using IR = {rd, imm}
    task automatic load_reg(input logic [7:0] rdn, input logic [7:0] val);
        load_ir({rdn, val});
        inm = 1'b1; op = 4'd0; wac = 1'b1; pulse();
        rac = 1'b1; wreg = 1'b1; pulse();
    endtask

    task automatic read_ac(output logic [7:0] val);
        rac = 1'b1; wmdr = 1'b1; pulse();
        val = ram_if.ram_wdata;
    endtask

    task automatic read_sp(output logic [7:0] val);
        rsp = 1'b1; wmar = 1'b1; pulse();
        val = ram_if.ram_addr;
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] ac;
        logic [3:0] vnzc;
    } alu_vec_t;

    alu_vec_t vecs [20];

    // ---------------- behavioural model ----------------
    int m_pc, m_sp, m_ac, m_ir, m_mar, m_mdr;
    int m_regs [NREG];
    int m_v, m_n, m_z, m_c, m_ovf, m_unf, m_berr;
    int m_mode; // 0 idle, 1 reading, 2 writing

    task automatic model_reset();
        m_pc = 0; m_sp = 255; m_ac = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
        foreach (m_regs[i]) m_regs[i] = 0;
        m_v = 0; m_n = 0; m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0; m_berr = 0;
        m_mode = 0;
    endtask

    function automatic int in_range(input int s);
        return (s > 127 || s < -128) ? 1 : 0;
    endfunction

    function automatic void model_alu(input int opc, input int a, input int b, input int cin,
                                      output int r, output int fv, output int fc);
        int s, sa, sb;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        fv = 0; fc = 0; s = 0;
        case (opc)
            0:  s = b;
            1:  begin s = a + b; fc = (s > 255); fv = in_range(sa + sb); end
            2, 13: begin s = a - b; fc = (s < 0); fv = in_range(sa - sb); end
            3:  s = a & b;
            4:  s = a | b;
            5:  s = a ^ b;
            6:  s = 255 - a;
            7:  begin s = a + 1; fc = (s > 255); fv = in_range(sa + 1); end
            8:  begin s = a - 1; fc = (s < 0); fv = in_range(sa - 1); end
            9:  begin s = a * 2; fc = (a >= 128); end
            10: begin s = a / 2; fc = a % 2; end
            11: begin s = a + b + cin; fc = (s > 255); fv = in_range(sa + sb + cin); end
            12: begin s = a - b - (1 - cin); fc = (s < 0); fv = in_range(sa - sb - (1 - cin)); end
            14: s = a;
            default: s = 0;
        endcase
        r = s & 255;
    endfunction

    task automatic model_step();
        int bus, nsrc, rdi, rai, a, b, r, fv, fc;
        nsrc = int'(rpc) + int'(rsp) + int'(rac) + int'(rmdr);
        if (rpc)       bus = m_pc;
        else if (rsp)  bus = m_sp;
        else if (rac)  bus = m_ac;
        else if (rmdr) bus = m_mdr;
        else           bus = 0;
        rdi = (m_ir / 256) % NREG;
        rai = m_ir % NREG;
        a = m_regs[rdi];
        b = inm ? (m_ir % 256) : m_regs[rai];
        model_alu(int'(op), a, b, m_c, r, fv, fc);
        if (nsrc > 1) m_berr = 1;
        if (cpc)      m_pc = 0;
        else if (wpc) m_pc = bus;
        else if (ipc) m_pc = (m_pc + 1) % 256;
        if (wreg) m_regs[rdi] = bus;
        if (wac && op != 4'd13) m_ac = r;
        if (ws) begin m_v = fv; m_c = fc; m_n = (r >= 128); m_z = (r == 0); end
        if (wir) m_ir = int'(code_data);
        if (wmar) m_mar = bus;
        if (m_mode == 1 && ram_if.ram_ack) m_mdr = int'(ram_if.ram_rdata);
        else if (wmdr)                     m_mdr = bus;
        if (csp) begin m_sp = 255; m_ovf = 0; m_unf = 0; end
        else if (isp && !dsp) begin if (m_sp == 255) m_ovf = 1; else m_sp++; end
        else if (dsp && !isp) begin if (m_sp == 0) m_unf = 1; else m_sp--; end
        if (m_mode == 0) begin
            if (wmem)      m_mode = 2;
            else if (rmem) m_mode = 1;
        end else if (ram_if.ram_ack) begin
            m_mode = 0;
        end
    endtask

    function automatic logic rb(input int unsigned pct);
        return $urandom_range(99) < pct;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] val;
        int busy_cnt;

        vecs[0]  = '{4'd1,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100};
        vecs[1]  = '{4'd1,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011};
        vecs[2]  = '{4'd2,  8'h05, 8'h07, 1'b0, 8'hFE, 4'b0101};
        vecs[3]  = '{4'd2,  8'h80, 8'h01, 1'b0, 8'h7F, 4'b1000};
        vecs[4]  = '{4'd3,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
        vecs[5]  = '{4'd4,  8'h0F, 8'hA0, 1'b0, 8'hAF, 4'b0100};
        vecs[6]  = '{4'd5,  8'h55, 8'h55, 1'b0, 8'h00, 4'b0010};
        vecs[7]  = '{4'd6,  8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0100};
        vecs[8]  = '{4'd7,  8'h7F, 8'h00, 1'b0, 8'h80, 4'b1100};
        vecs[9]  = '{4'd8,  8'h00, 8'h00, 1'b0, 8'hFF, 4'b0101};
        vecs[10] = '{4'd9,  8'h81, 8'h00, 1'b0, 8'h02, 4'b0001};
        vecs[11] = '{4'd10, 8'h03, 8'h00, 1'b0, 8'h01, 4'b0001};
        vecs[12] = '{4'd11, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000};
        vecs[13] = '{4'd12, 8'h10, 8'h20, 1'b0, 8'hEF, 4'b0101};
        vecs[14] = '{4'd12, 8'h30, 8'h10, 1'b1, 8'h20, 4'b0000};
        vecs[15] = '{4'd13, 8'h42, 8'h42, 1'b0, 8'h42, 4'b0010};
        vecs[16] = '{4'd14, 8'h9C, 8'h00, 1'b0, 8'h9C, 4'b0100};
        vecs[17] = '{4'd15, 8'h5A, 8'h00, 1'b0, 8'h00, 4'b0010};
        vecs[18] = '{4'd0,  8'h00, 8'h77, 1'b0, 8'h77, 4'b0000};
        vecs[19] = '{4'd11, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b1100};

        clr();
        code_data = '0;
        ram_if.ram_rdata = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ---- reset state ----
        check("rst_pc", code_addr, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_req", ram_if.ram_req, 1'b0);
        check("rst_flags", {v, n, z, c}, 4'b0000);
        check("rst_sticky", {stk_ovf, stk_unf, bus_err}, 3'b000);
        check("rst_mar", ram_if.ram_addr, 8'h00);
        check("rst_mdr", ram_if.ram_wdata, 8'h00);
        check("rst_irhi", ir_hi, 8'h00);
        read_sp(val);
        check("rst_sp", val, 8'hFF);
        read_ac(val);
        check("rst_ac", val, 8'h00);

        // ---- PC wrap ----
        for (int i = 0; i < 255; i++) begin ipc = 1'b1; pulse(); end
        check("pc_255", code_addr, 8'hFF);
        ipc = 1'b1; pulse();
        check("pc_wrap", code_addr, 8'h00);

        // ---- ALU example with immediate ----
        load_reg(8'h01, 8'h7F);
        load_ir({8'h01, 8'h05});
        check("ir_hi", ir_hi, 8'h01);
        inm = 1'b1; op = 4'd1; wac = 1'b1; ws = 1'b1; pulse();
        check("ex_flags", {v, n, z, c}, 4'b1100);
        read_ac(val);
        check("ex_ac", val, 8'h84);

        // ---- ALU vector table ----
        load_reg(8'h03, 8'h80);
        for (int i = 0; i < 20; i++) begin
            load_reg(8'h01, vecs[i].a);
            load_reg(8'h02, vecs[i].b);
            load_ir({8'h03, 8'h00});
            op = vecs[i].cin ? 4'd9 : 4'd15; ws = 1'b1; pulse();
            check($sformatf("alu%0d_cin", i), c, vecs[i].cin);
            load_ir({8'h01, 8'h02});
            op = vecs[i].op; wac = 1'b1; ws = 1'b1; pulse();
            check($sformatf("alu%0d_vnzc", i), {v, n, z, c}, vecs[i].vnzc);
            read_ac(val);
            check($sformatf("alu%0d_ac", i), val, vecs[i].ac);
        end

        // ---- RAM read with three wait cycles ----
        load_ir({8'h01, 8'h20});
        inm = 1'b1; op = 4'd0; wac = 1'b1; pulse();
        rac = 1'b1; wmar = 1'b1; pulse();
        check("rd_mar", ram_if.ram_addr, 8'h20);
        rmem = 1'b1; pulse();
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy) busy_cnt++;
            check($sformatf("rd_we%0d", k), ram_if.ram_we, 1'b0);
            check($sformatf("rd_req%0d", k), ram_if.ram_req, 1'b1);
            ram_if.ram_rdata = 8'hA5;
            if (k == 3) begin
                ram_if.ram_ack = 1'b1;
                rac = 1'b1; wmdr = 1'b1;   // completed read must beat bus load
            end
            pulse();
        end
        check("rd_busy_cycles", busy_cnt, 4);
        check("rd_busy_end", busy, 1'b0);
        check("rd_mdr", ram_if.ram_wdata, 8'hA5);
        ram_if.ram_ack = 1'b1; pulse();   // ack while idle is ignored
        check("idle_ack", busy, 1'b0);

        // ---- stack limits ----
        csp = 1'b1; pulse();
        for (int i = 0; i < 255; i++) begin dsp = 1'b1; pulse(); end
        read_sp(val);
        check("sp_zero", val, 8'h00);
        check("unf_pre", stk_unf, 1'b0);
        dsp = 1'b1; pulse();
        check("unf_set", stk_unf, 1'b1);
        read_sp(val);
        check("sp_hold0", val, 8'h00);
        isp = 1'b1; dsp = 1'b1; pulse();
        read_sp(val);
        check("sp_both", val, 8'h00);
        csp = 1'b1; pulse();
        check("unf_clr", stk_unf, 1'b0);
        read_sp(val);
        check("sp_csp", val, 8'hFF);
        isp = 1'b1; pulse();
        check("ovf_set", stk_ovf, 1'b1);
        read_sp(val);
        check("sp_holdff", val, 8'hFF);

        // ---- bus conflict ----
        repeat (3) begin ipc = 1'b1; pulse(); end
        load_ir({8'h01, 8'h5A});
        inm = 1'b1; op = 4'd0; wac = 1'b1; pulse();
        check("berr_pre", bus_err, 1'b0);
        rac = 1'b1; rpc = 1'b1; wmdr = 1'b1; pulse();
        check("conf_bus", ram_if.ram_wdata, 8'h03);
        check("berr_set", bus_err, 1'b1);
        repeat (3) pulse();
        check("berr_sticky", bus_err, 1'b1);

        // ---- write wins, then asynchronous reset mid-transfer ----
        wmem = 1'b1; rmem = 1'b1; pulse();
        check("wr_we", ram_if.ram_we, 1'b1);
        check("wr_busy", busy, 1'b1);
        pulse();
        check("wr_hold", ram_if.ram_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", ram_if.ram_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_berr", bus_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ---- randomized cycles against the model ----
        model_reset();
        for (int cyc = 0; cyc < 3000 && n_fail < 40; cyc++) begin
            check("rnd_pc", code_addr, m_pc);
            check("rnd_mar", ram_if.ram_addr, m_mar);
            check("rnd_mdr", ram_if.ram_wdata, m_mdr);
            check("rnd_irhi", ir_hi, m_ir / 256);
            check("rnd_flags", {v, n, z, c}, {m_v[0], m_n[0], m_z[0], m_c[0]});
            check("rnd_sticky", {stk_ovf, stk_unf, bus_err}, {m_ovf[0], m_unf[0], m_berr[0]});
            check("rnd_busy", busy, m_mode != 0);
            check("rnd_req", ram_if.ram_req, m_mode != 0);
            check("rnd_we", ram_if.ram_we, m_mode == 2);
            clr();
            case ($urandom_range(0, 4))
                1: rpc = 1'b1;
                2: rsp = 1'b1;
                3: rac = 1'b1;
                4: rmdr = 1'b1;
                default: ;
            endcase
            if ($urandom_range(0, 299) == 0) rmdr = 1'b1;
            wreg = rb(30); ws = rb(40); inm = rb(50); wac = rb(40);
            isp = rb(20); dsp = rb(20); csp = rb(3); ipc = rb(40);
            wpc = rb(10); wir = rb(30); cpc = rb(3); wmar = rb(20);
            wmdr = rb(20); rmem = rb(12); wmem = rb(8);
            op = 4'($urandom_range(0, 15));
            code_data = 16'($urandom);
            ram_if.ram_ack = rb(35);
            ram_if.ram_rdata = 8'($urandom);
            model_step();
            @(posedge clk);
            @(negedge clk);
        end
        clr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unidad_datos_p.md
Name: unidad_datos_p

Overview:
Parametrised next-generation datapath for the DAPA processor family. It holds the PC, SP, AC, IR, SR, MAR, MDR, register file and ALU. The internal tristate bus is replaced by a priority-muxed bus with conflict detection. Program memory sits outside the block. Data RAM is reached through a req/ack handshake with wait states, driven by a small transfer FSM that stalls the control unit through `busy`.

Parameters:
DW, 8, data/bus width (≥8)
AW, 8, data and code address width
NREG, 8, register count, power of 2, 2..16; RSW = log2(NREG)
SP_INIT, {AW{1'b1}}, SP value after reset or csp

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state
wreg, ws, inm, wac, rac, isp, dsp, csp, rsp, ipc, wpc, rpc, wir, cpc, wmar, wmdr, rmdr  in  1 each  control-unit strobes
op  in  4  ALU operation
rmem, wmem  in  1  start RAM read / write (single-cycle pulse)
code_addr  out  AW  PC to program memory
code_data  in  2*DW  instruction word
ram_addr  out  AW  MAR contents
ram_wdata  out  DW  MDR contents
ram_rdata  in  DW  RAM read data
ram_req  out  1  transfer request
ram_we  out  1  1 = write transfer
ram_ack  in  1  RAM completes transfer
busy  out  1  transfer in progress; UC must hold strobes
ir_hi  out  DW  IR[2*DW-1:DW] to UC
v, n, z, c  out  1  SR flags
stk_ovf, stk_unf  out  1  sticky stack errors
bus_err  out  1  sticky multiple-driver error

Behaviour:
- Reset (reset=0, asynchronous): PC, AC, IR, MAR, MDR, SR and all registers = 0. SP = SP_INIT. FSM = IDLE. All sticky flags = 0. ram_req = 0, busy = 0.
- Internal bus, combinational priority: rpc > rsp > rac > rmdr; 0 if none asserted. Two or more asserted in one cycle: bus_err set on next edge, stays set until reset.
- PC: cpc → 0 (synchronous). Else wpc → bus. Else ipc → PC+1, wraps at 2^AW. Priority cpc > wpc > ipc. code_addr = PC.
- IR: wir → code_data. ir_hi = IR[2*DW-1:DW].
- Instruction fields: rd = IR[DW+RSW-1:DW], ra = IR[RSW-1:0], imm = IR[DW-1:0].
- ALU operands: A = reg[rd]; B = inm ? imm : reg[ra].
- ALU op codes: 0 B; 1 A+B; 2 A-B; 3 A&B; 4 A|B; 5 A^B; 6 ~A; 7 A+1; 8 A-1; 9 A<<1; 10 A>>1; 11 A+B+c; 12 A-B-~c; 13 A-B (flags only, AC not written even if wac); 14 A; 15 0.
- Flags: c = carry/borrow out or shifted-out bit. z = result==0. n = result MSB. v = signed overflow for add/sub ops, else 0. ws → SR updated.
- AC: wac → ALU result (except op 13). reg[rd] ← bus on wreg; same-cycle read returns the old value.
- MAR: wmar → bus. MDR: wmdr → bus. Completed read → ram_rdata. If both occur in one cycle, the completed read wins.
- SP: csp → SP_INIT and clears stk_ovf/stk_unf. isp at all-ones → SP holds, stk_ovf=1. dsp at 0 → SP holds, stk_unf=1. Otherwise isp/dsp ±1. isp and dsp together → no change.
- Transfer FSM: IDLE, RD, WR.
  - IDLE: wmem → WR (wmem wins over rmem); rmem → RD.
  - RD/WR: ram_req=1, busy=1, ram_we=(state==WR). ram_addr/ram_wdata stable from MAR/MDR.
  - ram_ack in RD/WR → MDR captures on read; return to IDLE with busy=0 next cycle.
  - ram_ack in IDLE is ignored. rmem/wmem outside IDLE are ignored.
  - No timeout. Minimum transfer = 2 cycles (start edge, ack edge).
- Reset mid-transfer: FSM → IDLE immediately, ram_req drops asynchronously.

Test Plan:
- Reset release → PC=0, SP=0xFF, AC=0, busy=0, all flags 0; then ipc ×256 → PC wraps to 0.
- IR={8'h01,8'h05}, inm=1, reg[1]=0x7F, op=1, wac, ws → AC=0x84, v=1, n=1, z=0, c=0.
- rmem pulse, MAR=0x20, ram_ack after 3 wait cycles with rdata=0xA5 → busy high 4 cycles, MDR=0xA5, ram_we=0 throughout.
- SP=0x00, dsp → SP stays 0x00, stk_unf=1; then csp → SP=0xFF, stk_unf=0.
- rac and rpc in same cycle → bus carries PC, bus_err=1 and stays set.
- wmem and rmem together, then reset=0 two cycles later → WR entered (ram_we=1); ram_req falls at reset assertion without waiting for clk.
